// File: rtl/dsi_video_timing_gen.sv
// dsi_video_timing_gen
//   Generates the parallel video stream (VSYNC/HSYNC/DE/PIXDATA) that feeds the
//   DSI byte packetizer. Pixels come from an external ready/valid source or from
//   one of three internal test patterns. Single clock domain (PIXCLK).
//
// Ports
//   PIXCLK, reset      clock, asynchronous active-high reset
//   enable             run request; a running frame always completes
//   pattern_sel        0 external, 1 colour bars, 2 solid, 3 gradient
//   solid_color        colour used by pattern 2
//   ext_pixdata/valid  external pixel source
//   ext_ready          combinational pixel request (one cycle ahead of DE)
//   underflow_clr      clears the sticky underflow flag
//   VSYNC/HSYNC/DE     registered timing outputs, active-high
//   PIXDATA            registered pixel {R,G,B}, zero outside DE
//   frame_start        pulse with the first VSYNC cycle of each frame
//   underflow          sticky: an external pixel was missing during DE
//
// state | meaning
// IDLE  | counters held at 0, all outputs low
// RUN   | counters sweep the frame; exit only on the last cycle of a frame
module dsi_video_timing_gen #(
  parameter int H_ACTIVE   = 240,
  parameter int H_SYNC     = 10,
  parameter int H_BP       = 20,
  parameter int H_FP       = 20,
  parameter int V_ACTIVE   = 240,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 4,
  parameter int V_FP       = 4,
  parameter int word_width = 24,
  parameter logic [word_width-1:0] FILL = '0
) (
  input  logic                  PIXCLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [word_width-1:0] solid_color,
  input  logic [word_width-1:0] ext_pixdata,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  underflow_clr,
  output logic                  VSYNC,
  output logic                  HSYNC,
  output logic                  DE,
  output logic [word_width-1:0] PIXDATA,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int BAR_W   = H_ACTIVE / 8;

  typedef logic [15:0] cnt_t;

  localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_START = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t V_ACT_START = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  cnt_t                  h_cnt, h_nxt;
  cnt_t                  v_cnt, v_nxt;
  logic [1:0]            pat_q;
  logic [word_width-1:0] solid_q;

  logic                  run, active, at_origin;
  cnt_t                  x;
  logic [7:0]            y, xy_sum;
  logic [2:0]            bar;
  logic [word_width-1:0] pix;

  always_ff @(posedge PIXCLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          if (v_cnt == V_LAST) begin
            v_nxt = '0;
            if (!enable) state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + 16'd1;
          end
        end else begin
          h_nxt = h_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run       = (state == RUN);
    active    = run &&
                (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
                (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    at_origin = run && (h_cnt == '0) && (v_cnt == '0);
    ext_ready = active && (pat_q == 2'd0);
  end

  // Source selection is frozen for the whole frame at its first cycle.
  always_ff @(posedge PIXCLK or posedge reset) begin
    if (reset) begin
      pat_q   <= '0;
      solid_q <= '0;
    end else if (at_origin) begin
      pat_q   <= pattern_sel;
      solid_q <= solid_color;
    end
  end

  // Bar index by threshold compare avoids a divider for non-power-of-two widths.
  always_comb begin
    x      = h_cnt - H_ACT_START;
    y      = v_cnt[7:0] - V_ACT_START[7:0];
    xy_sum = x[7:0] + y;
    bar    = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= cnt_t'(i * BAR_W)) bar = bar + 3'd1;
    end
    pix = '0;
    case (pat_q)
      2'd0: pix = ext_valid ? ext_pixdata : FILL;
      2'd1: begin
        case (bar)
          3'd0: pix = word_width'(24'hFFFFFF);
          3'd1: pix = word_width'(24'hFFFF00);
          3'd2: pix = word_width'(24'h00FFFF);
          3'd3: pix = word_width'(24'h00FF00);
          3'd4: pix = word_width'(24'hFF00FF);
          3'd5: pix = word_width'(24'hFF0000);
          3'd6: pix = word_width'(24'h0000FF);
          default: pix = word_width'(24'h000000);
        endcase
      end
      2'd2: pix = solid_q;
      default: pix = word_width'({x[7:0], y, xy_sum});
    endcase
  end

  always_ff @(posedge PIXCLK or posedge reset) begin
    if (reset) begin
      HSYNC       <= 1'b0;
      VSYNC       <= 1'b0;
      DE          <= 1'b0;
      PIXDATA     <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      HSYNC       <= run && (h_cnt < H_SYNC_END);
      VSYNC       <= run && (v_cnt < V_SYNC_END);
      DE          <= active;
      PIXDATA     <= active ? pix : '0;
      frame_start <= at_origin;
      // A new miss wins over a simultaneous clear.
      if (active && (pat_q == 2'd0) && !ext_valid) underflow <= 1'b1;
      else if (underflow_clr)                       underflow <= 1'b0;
    end
  end

endmodule

// File: doc/dsi_video_timing_gen.md
Name: dsi_video_timing_gen

Overview:
Pixel-side source that generates the parallel video interface (VSYNC, HSYNC, DE, 24-bit RGB888 PIXDATA) consumed by the DSI byte packetizer, timed for the 240x240 LH154Q01 panel (240 px = 720-byte long packet, WC 16'h02d0).
Pixels come either from an external frame source over a ready/valid handshake or from an internal test pattern.
Runs entirely in the PIXCLK domain, directly upstream of the DSI TX top level.

Parameters:
H_ACTIVE, 240, active pixels per line; must be divisible by 8.
H_SYNC, 10, HSYNC width in PIXCLK cycles, at least 1.
H_BP, 20, horizontal back porch in cycles.
H_FP, 20, horizontal front porch in cycles.
V_ACTIVE, 240, active lines per frame.
V_SYNC, 2, VSYNC width in lines, at least 1.
V_BP, 4, vertical back porch in lines.
V_FP, 4, vertical front porch in lines.
word_width, 24, pixel bus width (RGB888).
FILL, 24'h000000, pixel substituted on underflow.

Ports:
PIXCLK  in  1  pixel clock; the only clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  run request.
pattern_sel  in  2  source select: 0 external, 1 colour bars, 2 solid, 3 gradient.
solid_color  in  24  colour for pattern 2.
ext_pixdata  in  24  external pixel.
ext_valid  in  1  external pixel valid.
ext_ready  out  1  pixel request; transfer when ext_ready & ext_valid.
underflow_clr  in  1  clears the underflow flag.
VSYNC  out  1  vertical sync, active-high.
HSYNC  out  1  horizontal sync, active-high.
DE  out  1  data enable.
PIXDATA  out  24  pixel {R[23:16],G[15:8],B[7:0]}.
frame_start  out  1  one-cycle pulse coincident with the first VSYNC cycle of each frame.
underflow  out  1  sticky underflow flag.

Behaviour:
- Reset: all outputs 0; h_cnt = v_cnt = 0; state IDLE.
- Frame geometry:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
  - V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
  - h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt at the wrap.
  - v_cnt wraps V_TOTAL-1 -> 0.
- Segment order for both h and v: sync, back porch, active, front porch.
- State machine IDLE / RUN:
  - IDLE -> RUN when enable=1 is sampled; counters start at 0.
  - RUN -> IDLE only at the end of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) when enable=0. A frame is never truncated.
  - In IDLE the counters hold 0 and all outputs are 0.
- Timing of registered outputs: every output except ext_ready is registered and reflects the counter state of the previous cycle (latency 1).
  - HSYNC = 1 for h_cnt < H_SYNC.
  - VSYNC = 1 for v_cnt < V_SYNC, covering whole lines and aligned to h_cnt = 0.
  - DE = 1 when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - frame_start = 1 for h_cnt=0 and v_cnt=0 in RUN.
- ext_ready: combinational = RUN & active-window & (latched pattern == 0). It is high exactly in the cycle before the corresponding DE=1 cycle. Its value is ignored by the source outside the active window.
- Pattern latch: pattern_sel and solid_color are latched at h_cnt=0, v_cnt=0 (frame start). Changes mid-frame have no effect until the next frame.
- PIXDATA when DE=1, by latched pattern:
  - 0: ext_pixdata if ext_valid, else FILL; in the FILL case underflow is set.
  - 1: 8 equal bars of H_ACTIVE/8 px in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 2: solid_color.
  - 3: with x, y = active pixel and line index from 0: R = x[7:0], G = y[7:0], B = (x+y)[7:0] mod 256.
- PIXDATA = 0 whenever DE = 0.
- underflow:
  - Set has priority over underflow_clr in the same cycle.
  - Cleared only by reset or by underflow_clr.
- Reset mid-frame: all outputs drop to 0 asynchronously, with no partial line afterwards. After reset the block restarts from IDLE.

Test Plan:
- Small geometry (H_ACTIVE=16, H_SYNC=2, H_BP=3, H_FP=1, V_ACTIVE=4, V_SYNC=1, V_BP=1, V_FP=1), pattern 2, enable=1 -> H_TOTAL=22, frame=154 cycles. HSYNC high 2 cycles/line; DE high 16 cycles on lines 2..5 only; frame_start every 154 cycles; first output one cycle after enable sampled.
- Pattern 1, default geometry -> each active line shows 30 px FFFFFF, then 30 px FFFF00 ... ending with 30 px 000000. PIXDATA=0 outside DE.
- Pattern 0, source holds ext_valid=1 with an incrementing value -> 240 transfers per active line; PIXDATA equals the value accepted one cycle earlier; underflow stays 0.
- Pattern 0, ext_valid dropped for 3 active cycles -> those 3 DE cycles carry 000000 and underflow=1. Asserting underflow_clr on the same cycle as a further miss leaves underflow=1; a clean underflow_clr returns it to 0.
- enable deasserted mid-frame, with pattern_sel changed mid-frame -> the frame completes fully with the old pattern, then all outputs are 0 and counters are 0 (IDLE).
- reset asserted mid-line while DE=1 -> DE, HSYNC, VSYNC and PIXDATA are 0 immediately. After release with enable=1, frame_start occurs with a full frame following.
